// File: rtl/branch_history_table.sv
// PC-indexed table of saturating counters with a post-reset clearing sweep and registered predictions.
// Build option BHT_BYPASS_EN: same-cycle, same-index lookup returns the post-update counter value.
module branch_history_table #(
    parameter int ENTRIES    = 64,
    parameter int CTR_WIDTH  = 2,
    parameter int PC_WIDTH   = 32,
    parameter int INIT_VALUE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [CTR_WIDTH-1:0] pred_ctr,
    input  logic                 update_valid,
    input  logic [PC_WIDTH-1:0]  update_pc,
    input  logic                 update_taken
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_VALUE);

    // state    | meaning
    // ST_INIT  | sweeping INIT_VALUE into every entry; traffic dropped
    // ST_RUN   | lookups and updates accepted; left only by reset
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     init_ptr_q, init_ptr_d;
    logic [CTR_WIDTH-1:0] table_q [ENTRIES];
    logic                 pred_valid_q;
    logic [CTR_WIDTH-1:0] pred_ctr_q;

    logic [IDX_W-1:0]     lk_idx, up_idx, wr_idx;
    logic [CTR_WIDTH-1:0] up_cur, up_new, lk_data, wr_data;
    logic                 lk_en, up_en, wr_en;
    logic                 unused_pc;

    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign up_idx    = update_pc[IDX_W+1:2];
    assign unused_pc = ^{lookup_pc, update_pc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + IDX_ONE;
            if (init_ptr_q == LAST_IDX) state_d = ST_RUN;
        end
    end

    always_comb begin
        ready   = (state_q == ST_RUN);
        lk_en   = ready && lookup_valid;
        up_en   = ready && update_valid;
        wr_en   = up_en;
        wr_idx  = up_idx;
        wr_data = up_new;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_ptr_q;
            wr_data = CTR_INIT;
        end
    end

    always_comb begin
        up_cur = table_q[up_idx];
        if (update_taken) up_new = (up_cur == CTR_MAX) ? up_cur : up_cur + CTR_ONE;
        else              up_new = (up_cur == '0)      ? up_cur : up_cur - CTR_ONE;
    end

`ifdef BHT_BYPASS_EN
    assign lk_data = (up_en && (up_idx == lk_idx)) ? up_new : table_q[lk_idx];
`else
    assign lk_data = table_q[lk_idx];
`endif

    // Contents are deliberately not reset; the INIT sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) table_q[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= lk_en;
            if (lk_en) pred_ctr_q <= lk_data;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_taken = pred_ctr_q[CTR_WIDTH-1];
endmodule
